nc_neighbour_buffer: RTL and testbench
======================================

Name: nc_neighbour_buffer

Overview:
- Sequential storage stage directly upstream of nC_decoding.
- Records the total_coeff of every luma and chroma 4x4 block as the CAVLC residual decoder produces it.
- Holds the above-row line buffer and the left-MB column register.
- Presents the packed up/left/current vectors that the nC predictor consumes for each block.

Parameters:
- MB_X_BITS, 7, width of the macroblock column index (matches `mb_x_bits).
- MAX_MB_W, 120, line-buffer depth in macroblocks (1920-pixel picture).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- mb_x_in  in  MB_X_BITS  column of MB being started
- mb_y_in  in  8  row of MB being started
- start_mb_in  in  1  one-cycle pulse, new MB begins
- end_mb_in  in  1  one-cycle pulse, current MB finished, commit neighbours
- fill_en_in  in  1  pulse, set every block of current MB to fill_val_in (skip=0, I_PCM=16)
- fill_val_in  in  5  fill value
- tc_wr_en_in  in  1  total_coeff write strobe
- tc_wr_type_in  in  2  0 luma, 1 Cb, 2 Cr, 3 ignored
- tc_wr_idx_in  in  4  luma4x4BlkIdx; bits [1:0] = chroma4x4BlkIdx
- tc_wr_data_in  in  5  total_coeff, 0..16
- nC_up_mb_out  out  32  byte j = upper-MB luma block {10,11,14,15}[j]
- nC_left_mb_out  out  32  byte j = left-MB luma block {5,7,13,15}[j]
- nC_curr_mb_out  out  128  byte k = current luma block k
- nC_cb_up_mb_out / nC_cr_up_mb_out  out  16  byte j = upper-MB chroma block {2,3}[j]
- nC_cb_left_mb_out / nC_cr_left_mb_out  out  16  byte j = left-MB chroma block {1,3}[j]
- nC_cb_curr_mb_out / nC_cr_curr_mb_out  out  32  byte k = current chroma block k
- nbr_valid_out  out  1  neighbour vectors valid for current MB

Behaviour:
- All stored bytes are 8 bits: value zero-extended from 5 bits, upper 3 bits always 0.
- Reset (rst_n=0 at a rising edge): all outputs 0, nbr_valid_out=0, left register 0, latched mb_x 0. Line buffer RAM is not reset.
- States: IDLE and MB_ACTIVE.
- start_mb_in, latency 1 cycle, at next edge:
  - latch mb_x_in;
  - up outputs <= line_buf[mb_x_in], forced 0 when mb_y_in==0;
  - left outputs <= left register, forced 0 when mb_x_in==0;
  - all curr bytes <= 0;
  - nbr_valid_out <= 1; state MB_ACTIVE.
- tc_wr_en_in in MB_ACTIVE writes the addressed curr byte at next edge. Readable the cycle after the strobe. Ignored in IDLE or when type==3.
- fill_en_in in MB_ACTIVE writes all 16 luma and 8 chroma curr bytes.
  - fill beats a same-cycle tc write; that write is discarded.
- end_mb_in in MB_ACTIVE, at next edge:
  - line_buf[latched x] <= {luma 10,11,14,15; Cb 2,3; Cr 2,3}, 64 bits;
  - left register <= {luma 5,7,13,15; Cb 1,3; Cr 1,3};
  - nbr_valid_out <= 0; state IDLE.
  - A tc write or fill in the same cycle is merged into the committed data.
- end_mb_in and start_mb_in in the same cycle:
  - commit first, then start;
  - left outputs forward the just-committed column;
  - up outputs forward the committed row if mb_x_in equals the latched x (picture width 1 MB).
  - Result: nbr_valid_out stays 1.
- start_mb_in while MB_ACTIVE without end: restart; the old MB is discarded, not committed.
- end_mb_in in IDLE: ignored.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- mb_x_in >= MAX_MB_W on start: no line-buffer access; up outputs 0.

Test Plan:
- Reset then start at (x=0,y=0) -> all up/left outputs 0, curr 0, nbr_valid_out=1 one cycle after start.
- Write luma idx 5 = 7, Cb idx 3 = 2 -> nC_curr_mb_out[47:40]=7, nC_cb_curr_mb_out[31:24]=2 next cycle. Write with type 3 -> no change.
- MB (x=0,y=0): write luma 15=9, luma 10=4; end + start (x=1,y=0) same cycle -> nC_left_mb_out[31:24]=9, nbr_valid_out held 1, up outputs 0.
- Row 1, start (x=0,y=1) -> nC_up_mb_out[7:0]=4, nC_up_mb_out[31:24]=9.
- fill_en (value 16) with same-cycle tc write of 3 to luma 0 -> every curr byte 16. End, next MB at x+1 -> left luma bytes all 16, chroma left bytes 16.
- Reset asserted mid-MB after writes -> outputs 0, nbr_valid_out 0. A following end_mb_in is ignored; the line buffer entry is unchanged.

Source files
------------

// File: rtl/nc_neighbour_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nc_neighbour_buffer_if                                                   |
// | Control, total_coeff write and packed nC neighbour-vector bundle between |
// | the CAVLC residual decoder, the neighbour buffer and the nC predictor.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface nc_neighbour_buffer_if #(
   parameter int MB_X_BITS = 7
);
   // macroblock sequencing
   logic [MB_X_BITS-1:0] mb_x_in;
   logic [7:0]           mb_y_in;
   logic                 start_mb_in;
   logic                 end_mb_in;
   // whole-MB fill (skip / I_PCM)
   logic                 fill_en_in;
   logic [4:0]           fill_val_in;
   // per-block total_coeff write
   logic                 tc_wr_en_in;
   logic [1:0]           tc_wr_type_in;
   logic [3:0]           tc_wr_idx_in;
   logic [4:0]           tc_wr_data_in;
   // packed neighbour vectors
   logic [31:0]          nC_up_mb_out;
   logic [31:0]          nC_left_mb_out;
   logic [127:0]         nC_curr_mb_out;
   logic [15:0]          nC_cb_up_mb_out;
   logic [15:0]          nC_cr_up_mb_out;
   logic [15:0]          nC_cb_left_mb_out;
   logic [15:0]          nC_cr_left_mb_out;
   logic [31:0]          nC_cb_curr_mb_out;
   logic [31:0]          nC_cr_curr_mb_out;
   logic                 nbr_valid_out;

   modport master (
      output mb_x_in, mb_y_in, start_mb_in, end_mb_in,
      output fill_en_in, fill_val_in,
      output tc_wr_en_in, tc_wr_type_in, tc_wr_idx_in, tc_wr_data_in,
      input  nC_up_mb_out, nC_left_mb_out, nC_curr_mb_out,
      input  nC_cb_up_mb_out, nC_cr_up_mb_out,
      input  nC_cb_left_mb_out, nC_cr_left_mb_out,
      input  nC_cb_curr_mb_out, nC_cr_curr_mb_out,
      input  nbr_valid_out
   );

   modport slave (
      input  mb_x_in, mb_y_in, start_mb_in, end_mb_in,
      input  fill_en_in, fill_val_in,
      input  tc_wr_en_in, tc_wr_type_in, tc_wr_idx_in, tc_wr_data_in,
      output nC_up_mb_out, nC_left_mb_out, nC_curr_mb_out,
      output nC_cb_up_mb_out, nC_cr_up_mb_out,
      output nC_cb_left_mb_out, nC_cr_left_mb_out,
      output nC_cb_curr_mb_out, nC_cr_curr_mb_out,
      output nbr_valid_out
   );
endinterface
`default_nettype wire

// File: rtl/nc_neighbour_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nc_neighbour_buffer                                                      |
// | Records total_coeff of every 4x4 luma/chroma block of the current MB,    |
// | keeps the above-row line buffer and the left-MB column register, and     |
// | presents registered up/left/current vectors to the nC predictor.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nc_neighbour_buffer #(
   parameter int MB_X_BITS = 7,
   parameter int MAX_MB_W  = 120
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   nc_neighbour_buffer_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      MB_ACTIVE = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   // Neighbour record layout (5-bit fields, index 0 first):
   //   up   : luma 10,11,14,15, Cb 2,3, Cr 2,3
   //   left : luma  5, 7,13,15, Cb 1,3, Cr 1,3
   logic [7:0][4:0]      line_buf [MAX_MB_W];
   logic [7:0][4:0]      left_reg;
   logic [7:0][4:0]      up_q;
   logic [7:0][4:0]      left_q;
   logic [15:0][4:0]     luma_q;
   logic [3:0][4:0]      cb_q;
   logic [3:0][4:0]      cr_q;
   logic [MB_X_BITS-1:0] cur_x;

   logic [15:0][4:0]     luma_d;
   logic [3:0][4:0]      cb_d;
   logic [3:0][4:0]      cr_d;
   logic [7:0][4:0]      commit_up;
   logic [7:0][4:0]      commit_left;
   logic [7:0][4:0]      up_sel;
   logic [7:0][4:0]      left_sel;
   logic                 active;
   logic                 do_commit;
   logic                 x_in_range;
   logic                 cur_in_range;
   logic [MB_X_BITS-1:0] rd_x;

   assign active       = (state_q == MB_ACTIVE);
   assign do_commit    = active & bus.end_mb_in;
   assign x_in_range   = (int'(bus.mb_x_in) < MAX_MB_W);
   assign cur_in_range = (int'(cur_x) < MAX_MB_W);
   assign rd_x         = x_in_range ? bus.mb_x_in : '0;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: a start always (re)opens an MB, a lone end closes it
   always_comb begin
      state_d = state_q;
      if (bus.start_mb_in)  state_d = MB_ACTIVE;
      else if (do_commit)   state_d = IDLE;
   end

   // Current-MB contents after this cycle's fill or block write; fill wins
   always_comb begin
      luma_d = luma_q;
      cb_d   = cb_q;
      cr_d   = cr_q;
      if (active) begin
         if (bus.fill_en_in) begin
            for (int k = 0; k < 16; k++) luma_d[k] = bus.fill_val_in;
            for (int k = 0; k < 4; k++) begin
               cb_d[k] = bus.fill_val_in;
               cr_d[k] = bus.fill_val_in;
            end
         end else if (bus.tc_wr_en_in) begin
            case (bus.tc_wr_type_in)
               2'd0:    luma_d[bus.tc_wr_idx_in]    = bus.tc_wr_data_in;
               2'd1:    cb_d[bus.tc_wr_idx_in[1:0]] = bus.tc_wr_data_in;
               2'd2:    cr_d[bus.tc_wr_idx_in[1:0]] = bus.tc_wr_data_in;
               default: ;
            endcase
         end
      end
   end

   // Committed records include any same-cycle write, so end never loses data
   assign commit_up   = {cr_d[3], cr_d[2], cb_d[3], cb_d[2],
                         luma_d[15], luma_d[14], luma_d[11], luma_d[10]};
   assign commit_left = {cr_d[3], cr_d[1], cb_d[3], cb_d[1],
                         luma_d[15], luma_d[13], luma_d[7], luma_d[5]};

   // Neighbour selection for a starting MB, forwarding a same-cycle commit
   always_comb begin
      up_sel   = '0;
      left_sel = '0;
      if (bus.mb_y_in != 8'd0 && x_in_range) begin
         if (do_commit && bus.mb_x_in == cur_x) up_sel = commit_up;
         else                                   up_sel = line_buf[rd_x];
      end
      if (bus.mb_x_in != '0) begin
         if (do_commit) left_sel = commit_left;
         else           left_sel = left_reg;
      end
   end

   // Datapath registers: current MB, neighbour outputs, left column, x latch
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         left_reg <= '0;
         up_q     <= '0;
         left_q   <= '0;
         luma_q   <= '0;
         cb_q     <= '0;
         cr_q     <= '0;
         cur_x    <= '0;
      end else begin
         if (do_commit) left_reg <= commit_left;
         if (bus.start_mb_in) begin
            cur_x  <= bus.mb_x_in;
            up_q   <= up_sel;
            left_q <= left_sel;
            luma_q <= '0;
            cb_q   <= '0;
            cr_q   <= '0;
         end else begin
            luma_q <= luma_d;
            cb_q   <= cb_d;
            cr_q   <= cr_d;
         end
      end
   end

   // Line buffer write of the finished MB's bottom row (RAM has no reset)
   always_ff @(posedge clk) begin
      if (rst_n && do_commit && cur_in_range) line_buf[cur_x] <= commit_up;
   end

   // Byte-wide zero-extended output packing
   for (genvar j = 0; j < 4; j++) begin : g_luma_nbr
      assign bus.nC_up_mb_out[8*j +: 8]   = {3'b000, up_q[j]};
      assign bus.nC_left_mb_out[8*j +: 8] = {3'b000, left_q[j]};
   end

   for (genvar j = 0; j < 2; j++) begin : g_chroma_nbr
      assign bus.nC_cb_up_mb_out[8*j +: 8]   = {3'b000, up_q[4+j]};
      assign bus.nC_cr_up_mb_out[8*j +: 8]   = {3'b000, up_q[6+j]};
      assign bus.nC_cb_left_mb_out[8*j +: 8] = {3'b000, left_q[4+j]};
      assign bus.nC_cr_left_mb_out[8*j +: 8] = {3'b000, left_q[6+j]};
   end

   for (genvar k = 0; k < 16; k++) begin : g_luma_curr
      assign bus.nC_curr_mb_out[8*k +: 8] = {3'b000, luma_q[k]};
   end

   for (genvar k = 0; k < 4; k++) begin : g_chroma_curr
      assign bus.nC_cb_curr_mb_out[8*k +: 8] = {3'b000, cb_q[k]};
      assign bus.nC_cr_curr_mb_out[8*k +: 8] = {3'b000, cr_q[k]};
   end

   assign bus.nbr_valid_out = active;

endmodule
`default_nettype wire

// File: tb/tb_nc_neighbour_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nc_neighbour_buffer                                                   |
// | Directed test-plan sequence with literal expectations, then randomized   |
// | traffic compared every cycle against a whole-macroblock model.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_nc_neighbour_buffer;
   localparam int MBXB = 7;
   localparam int MAXW = 120;
   localparam int UL[4] = '{10, 11, 14, 15};
   localparam int LL[4] = '{5, 7, 13, 15};
   localparam int CU[2] = '{2, 3};
   localparam int CL[2] = '{1, 3};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nc_neighbour_buffer_if #(.MB_X_BITS(MBXB)) bus ();

   nc_neighbour_buffer #(.MB_X_BITS(MBXB), .MAX_MB_W(MAXW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: whole macroblocks, indexed by block number -------
   int  lb_l [MAXW][16];
   int  lb_c [MAXW][2][4];
   bit  lb_known [MAXW];
   int  cur_l [16];
   int  cur_c [2][4];
   int  up_l [16];
   int  up_c [2][4];
   int  lf_l [16];
   int  lf_c [2][4];
   int  lr_l [16];
   int  lr_c [2][4];
   int  nl [16];
   int  nc [2][4];
   bit  m_active = 1'b0;
   int  m_x = 0;
   bit  up_known = 1'b1;

   initial begin
      for (int i = 0; i < MAXW; i++) lb_known[i] = 1'b0;
   end

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) begin
            cur_l[k] = 0; up_l[k] = 0; lf_l[k] = 0; lr_l[k] = 0;
         end
         for (int c = 0; c < 2; c++)
            for (int k = 0; k < 4; k++) begin
               cur_c[c][k] = 0; up_c[c][k] = 0; lf_c[c][k] = 0; lr_c[c][k] = 0;
            end
         m_active = 1'b0;
         m_x      = 0;
         up_known = 1'b1;
      end else begin
         for (int k = 0; k < 16; k++) nl[k] = cur_l[k];
         for (int c = 0; c < 2; c++)
            for (int k = 0; k < 4; k++) nc[c][k] = cur_c[c][k];
         if (m_active) begin
            if (bus.fill_en_in) begin
               for (int k = 0; k < 16; k++) nl[k] = int'(bus.fill_val_in);
               for (int c = 0; c < 2; c++)
                  for (int k = 0; k < 4; k++) nc[c][k] = int'(bus.fill_val_in);
            end else if (bus.tc_wr_en_in) begin
               if (bus.tc_wr_type_in == 2'd0)
                  nl[bus.tc_wr_idx_in] = int'(bus.tc_wr_data_in);
               else if (bus.tc_wr_type_in != 2'd3)
                  nc[int'(bus.tc_wr_type_in) - 1][bus.tc_wr_idx_in[1:0]] = int'(bus.tc_wr_data_in);
            end
         end
         if (m_active && bus.end_mb_in) begin
            if (m_x < MAXW) begin
               for (int k = 0; k < 16; k++) lb_l[m_x][k] = nl[k];
               for (int c = 0; c < 2; c++)
                  for (int k = 0; k < 4; k++) lb_c[m_x][c][k] = nc[c][k];
               lb_known[m_x] = 1'b1;
            end
            for (int k = 0; k < 16; k++) lr_l[k] = nl[k];
            for (int c = 0; c < 2; c++)
               for (int k = 0; k < 4; k++) lr_c[c][k] = nc[c][k];
         end
         if (bus.start_mb_in) begin
            m_x = int'(bus.mb_x_in);
            if (bus.mb_y_in == 8'd0 || m_x >= MAXW) begin
               for (int k = 0; k < 16; k++) up_l[k] = 0;
               for (int c = 0; c < 2; c++)
                  for (int k = 0; k < 4; k++) up_c[c][k] = 0;
               up_known = 1'b1;
            end else begin
               for (int k = 0; k < 16; k++) up_l[k] = lb_l[m_x][k];
               for (int c = 0; c < 2; c++)
                  for (int k = 0; k < 4; k++) up_c[c][k] = lb_c[m_x][c][k];
               up_known = lb_known[m_x];
            end
            for (int k = 0; k < 16; k++) lf_l[k] = (m_x == 0) ? 0 : lr_l[k];
            for (int c = 0; c < 2; c++)
               for (int k = 0; k < 4; k++) lf_c[c][k] = (m_x == 0) ? 0 : lr_c[c][k];
            for (int k = 0; k < 16; k++) cur_l[k] = 0;
            for (int c = 0; c < 2; c++)
               for (int k = 0; k < 4; k++) cur_c[c][k] = 0;
            m_active = 1'b1;
         end else begin
            for (int k = 0; k < 16; k++) cur_l[k] = nl[k];
            for (int c = 0; c < 2; c++)
               for (int k = 0; k < 4; k++) cur_c[c][k] = nc[c][k];
            if (m_active && bus.end_mb_in) m_active = 1'b0;
         end
      end
   end

   // ---------------- per-cycle comparison against the model -----------------
   initial forever begin
      logic [127:0] e_curr;
      logic [31:0]  e_up, e_lf, e_cbc, e_crc;
      logic [15:0]  e_cbu, e_cru, e_cbl, e_crl;
      @(negedge clk);
      if (checking) begin
         for (int k = 0; k < 16; k++) e_curr[8*k +: 8] = 8'(cur_l[k]);
         for (int j = 0; j < 4; j++) begin
            e_up[8*j +: 8]  = 8'(up_l[UL[j]]);
            e_lf[8*j +: 8]  = 8'(lf_l[LL[j]]);
            e_cbc[8*j +: 8] = 8'(cur_c[0][j]);
            e_crc[8*j +: 8] = 8'(cur_c[1][j]);
         end
         for (int j = 0; j < 2; j++) begin
            e_cbu[8*j +: 8] = 8'(up_c[0][CU[j]]);
            e_cru[8*j +: 8] = 8'(up_c[1][CU[j]]);
            e_cbl[8*j +: 8] = 8'(lf_c[0][CL[j]]);
            e_crl[8*j +: 8] = 8'(lf_c[1][CL[j]]);
         end
         chk("nbr_valid", 128'(bus.nbr_valid_out), 128'(m_active));
         chk("curr", bus.nC_curr_mb_out, e_curr);
         chk("cb_curr", 128'(bus.nC_cb_curr_mb_out), 128'(e_cbc));
         chk("cr_curr", 128'(bus.nC_cr_curr_mb_out), 128'(e_crc));
         chk("left", 128'(bus.nC_left_mb_out), 128'(e_lf));
         chk("cb_left", 128'(bus.nC_cb_left_mb_out), 128'(e_cbl));
         chk("cr_left", 128'(bus.nC_cr_left_mb_out), 128'(e_crl));
         if (up_known) begin
            chk("up", 128'(bus.nC_up_mb_out), 128'(e_up));
            chk("cb_up", 128'(bus.nC_cb_up_mb_out), 128'(e_cbu));
            chk("cr_up", 128'(bus.nC_cr_up_mb_out), 128'(e_cru));
         end
      end
   end

   // ---------------- stimulus helpers ----------------------------------------
   task automatic tick();
      @(negedge clk);
      bus.start_mb_in = 1'b0;
      bus.end_mb_in   = 1'b0;
      bus.fill_en_in  = 1'b0;
      bus.tc_wr_en_in = 1'b0;
   endtask

   task automatic wr(input int t, input int idx, input int data);
      bus.tc_wr_en_in   = 1'b1;
      bus.tc_wr_type_in = 2'(t);
      bus.tc_wr_idx_in  = 4'(idx);
      bus.tc_wr_data_in = 5'(data);
   endtask

   task automatic start(input int x, input int y);
      bus.start_mb_in = 1'b1;
      bus.mb_x_in     = MBXB'(x);
      bus.mb_y_in     = 8'(y);
   endtask

   initial begin
      bus.mb_x_in = '0; bus.mb_y_in = '0;
      bus.start_mb_in = 1'b0; bus.end_mb_in = 1'b0;
      bus.fill_en_in = 1'b0; bus.fill_val_in = '0;
      bus.tc_wr_en_in = 1'b0; bus.tc_wr_type_in = '0;
      bus.tc_wr_idx_in = '0; bus.tc_wr_data_in = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checking = 1'b1;
      chk("rst_valid", 128'(bus.nbr_valid_out), 128'd0);
      chk("rst_curr", bus.nC_curr_mb_out, 128'd0);
      chk("rst_left", 128'(bus.nC_left_mb_out), 128'd0);
      chk("rst_up", 128'(bus.nC_up_mb_out), 128'd0);
      rst_n = 1'b1;
      tick();

      // MB (0,0)
      start(0, 0); tick();
      chk("s00_valid", 128'(bus.nbr_valid_out), 128'd1);
      chk("s00_up", 128'(bus.nC_up_mb_out), 128'd0);
      chk("s00_left", 128'(bus.nC_left_mb_out), 128'd0);
      wr(0, 5, 7); tick();
      chk("wr_l5", 128'(bus.nC_curr_mb_out[47:40]), 128'd7);
      wr(1, 3, 2); tick();
      chk("wr_cb3", 128'(bus.nC_cb_curr_mb_out[31:24]), 128'd2);
      wr(3, 5, 1); tick();
      chk("t3_curr", bus.nC_curr_mb_out, 128'h00000000_00000000_00000700_00000000);
      chk("t3_cb", 128'(bus.nC_cb_curr_mb_out), 128'h02000000);
      wr(0, 15, 9); tick();
      wr(0, 10, 4); tick();
      // end + start (1,0)
      bus.end_mb_in = 1'b1; start(1, 0); tick();
      chk("es_left", 128'(bus.nC_left_mb_out), 128'h09000007);
      chk("es_cb_left", 128'(bus.nC_cb_left_mb_out), 128'h0200);
      chk("es_valid", 128'(bus.nbr_valid_out), 128'd1);
      chk("es_up", 128'(bus.nC_up_mb_out), 128'd0);
      wr(0, 14, 5); tick();
      bus.end_mb_in = 1'b1; tick();
      chk("end_valid", 128'(bus.nbr_valid_out), 128'd0);
      // row 1
      start(0, 1); tick();
      chk("r1_up", 128'(bus.nC_up_mb_out), 128'h09000004);
      chk("r1_cb_up", 128'(bus.nC_cb_up_mb_out), 128'h0200);
      chk("r1_left", 128'(bus.nC_left_mb_out), 128'd0);
      bus.fill_en_in = 1'b1; bus.fill_val_in = 5'd16; wr(0, 0, 3); tick();
      chk("fill_curr", bus.nC_curr_mb_out, {16{8'h10}});
      chk("fill_cb", 128'(bus.nC_cb_curr_mb_out), 128'h10101010);
      chk("fill_cr", 128'(bus.nC_cr_curr_mb_out), 128'h10101010);
      bus.end_mb_in = 1'b1; start(1, 1); tick();
      chk("f_left", 128'(bus.nC_left_mb_out), 128'h10101010);
      chk("f_cb_left", 128'(bus.nC_cb_left_mb_out), 128'h1010);
      chk("f_cr_left", 128'(bus.nC_cr_left_mb_out), 128'h1010);
      chk("f_up", 128'(bus.nC_up_mb_out), 128'h00050000);
      // reset mid-MB
      wr(0, 3, 11); tick();
      rst_n = 1'b0; tick();
      chk("mr_valid", 128'(bus.nbr_valid_out), 128'd0);
      chk("mr_curr", bus.nC_curr_mb_out, 128'd0);
      chk("mr_left", 128'(bus.nC_left_mb_out), 128'd0);
      chk("mr_up", 128'(bus.nC_up_mb_out), 128'd0);
      rst_n = 1'b1;
      bus.end_mb_in = 1'b1; tick();
      chk("idle_end_valid", 128'(bus.nbr_valid_out), 128'd0);
      start(1, 2); tick();
      chk("kept_up", 128'(bus.nC_up_mb_out), 128'h00050000);
      chk("kept_left", 128'(bus.nC_left_mb_out), 128'd0);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         int sel;
         rst_n = ($urandom_range(0, 199) != 0);
         sel = int'($urandom_range(0, 9));
         bus.mb_x_in = (sel < 8) ? MBXB'($urandom_range(0, 3)) : MBXB'($urandom_range(0, 127));
         bus.mb_y_in = 8'($urandom_range(0, 3));
         bus.start_mb_in = ($urandom_range(0, 11) == 0);
         bus.end_mb_in   = ($urandom_range(0, 9) == 0);
         bus.fill_en_in  = ($urandom_range(0, 29) == 0);
         sel = int'($urandom_range(0, 2));
         bus.fill_val_in = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd16 : 5'($urandom_range(0, 16));
         bus.tc_wr_en_in   = 1'($urandom_range(0, 1));
         bus.tc_wr_type_in = 2'($urandom_range(0, 3));
         bus.tc_wr_idx_in  = 4'($urandom_range(0, 15));
         bus.tc_wr_data_in = 5'($urandom_range(0, 16));
         @(negedge clk);
      end
      rst_n = 1'b1;
      tick();
      tick();
      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
